xnor_maj_layer_seq: RTL

//  Sequences one binarised neuron layer through a single registered XNOR-majority core.

---
 rtl/xnor_maj_layer_seq_if.sv | 28 ++
 rtl/xnor_maj_layer_seq.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/xnor_maj_layer_seq_if.sv
// Handshake and weight-ROM bundle for the XNOR-majority layer sequencer.
// The master side is the sequencer. The slave side is its environment: producer, ROM and consumer.
interface xnor_maj_layer_seq_if #(
  parameter int M  = 9,
  parameter int N  = 16,
  parameter int AW = (N > 1) ? $clog2(N) : 1
);
  logic          in_valid;
  logic          in_ready;
  logic [M-1:0]  in_act;
  logic          w_ren;
  logic [AW-1:0] w_addr;
  logic [M-1:0]  w_rdata;
  logic          out_valid;
  logic          out_ready;
  logic [N-1:0]  out_bits;
  logic          busy;

  modport master (
    input  in_valid, in_act, w_rdata, out_ready,
    output in_ready, w_ren, w_addr, out_valid, out_bits, busy
  );

  modport slave (
    output in_valid, in_act, w_rdata, out_ready,
    input  in_ready, w_ren, w_addr, out_valid, out_bits, busy
  );
endinterface

// File: rtl/xnor_maj_layer_seq.sv
// Binarised neuron layer: streams N weight rows through one registered XNOR-majority core
// and packs the N majority bits into a single output word.
module xnor_maj_core #(
  parameter int M = 9
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [M-1:0] a,
  input  logic [M-1:0] w,
  output logic         m
);
  logic [M-1:0] a_q, a_d, w_q, w_d;
  logic         m_q, m_d;

  function automatic logic maj(input logic [M-1:0] x);
    int cnt;
    cnt = 0;
    for (int i = 0; i < M; i++) begin
      if (x[i]) cnt++;
    end
    return cnt > M / 2;
  endfunction

  always_comb begin
    a_d = a;
    w_d = w;
    m_d = maj(~(a_q ^ w_q));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q <= '0;
      w_q <= '0;
      m_q <= 1'b0;
    end else begin
      a_q <= a_d;
      w_q <= w_d;
      m_q <= m_d;
    end
  end

  assign m = m_q;
endmodule

module xnor_maj_layer_seq #(
  parameter int M  = 9,
  parameter int N  = 16,
  parameter int AW = (N > 1) ? $clog2(N) : 1
) (
  input logic                clk,
  input logic                rst_n,
  xnor_maj_layer_seq_if.master bus
);
  localparam int             CW    = $clog2(N + 1);
  localparam logic [CW-1:0]  N_C   = CW'(N);
  localparam logic [CW-1:0]  ONE_C = CW'(1);
  localparam logic [1:0]     S_IDLE = 2'd0;
  localparam logic [1:0]     S_RUN  = 2'd1;
  localparam logic [1:0]     S_DONE = 2'd2;

  logic [1:0]    state_q, state_d;
  logic          in_ready_q, in_ready_d;
  logic [M-1:0]  act_q, act_d;
  logic          w_ren_q, w_ren_d;
  logic [AW-1:0] w_addr_q, w_addr_d;
  logic [CW-1:0] issue_cnt_q, issue_cnt_d;
  logic [CW-1:0] got_cnt_q, got_cnt_d;
  logic          vld_p0_q, vld_p0_d, vld_p1_q, vld_p1_d, vld_p2_q, vld_p2_d;
  logic [AW-1:0] idx_p0_q, idx_p0_d, idx_p1_q, idx_p1_d, idx_p2_q, idx_p2_d;
  logic [N-1:0]  out_bits_q, out_bits_d;
  logic          core_m;

  xnor_maj_core #(.M(M)) u_core (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (act_q),
    .w     (bus.w_rdata),
    .m     (core_m)
  );

  always_comb begin
    state_d     = state_q;
    act_d       = act_q;
    w_ren_d     = 1'b0;
    w_addr_d    = w_addr_q;
    issue_cnt_d = issue_cnt_q;
    got_cnt_d   = got_cnt_q;
    out_bits_d  = out_bits_q;
    // p0: ROM is returning the row; p1: core holds a/w; p2: core holds m
    vld_p0_d    = w_ren_q;
    idx_p0_d    = w_addr_q;
    vld_p1_d    = vld_p0_q;
    idx_p1_d    = idx_p0_q;
    vld_p2_d    = vld_p1_q;
    idx_p2_d    = idx_p1_q;

    case (state_q)
      S_IDLE: begin
        if (bus.in_valid && in_ready_q) begin
          act_d       = bus.in_act;
          out_bits_d  = '0;
          got_cnt_d   = '0;
          w_ren_d     = 1'b1;
          w_addr_d    = '0;
          issue_cnt_d = ONE_C;
          state_d     = S_RUN;
        end
      end
      S_RUN: begin
        if (issue_cnt_q < N_C) begin
          w_ren_d     = 1'b1;
          w_addr_d    = issue_cnt_q[AW-1:0];
          issue_cnt_d = issue_cnt_q + ONE_C;
        end
        if (vld_p2_q) begin
          out_bits_d[idx_p2_q] = core_m;
          got_cnt_d            = got_cnt_q + ONE_C;
          if (got_cnt_q == N_C - ONE_C) state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (bus.out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Registered so it stays low through reset and rises the cycle after release.
    in_ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      in_ready_q  <= 1'b0;
      act_q       <= '0;
      w_ren_q     <= 1'b0;
      w_addr_q    <= '0;
      issue_cnt_q <= '0;
      got_cnt_q   <= '0;
      vld_p0_q    <= 1'b0;
      vld_p1_q    <= 1'b0;
      vld_p2_q    <= 1'b0;
      idx_p0_q    <= '0;
      idx_p1_q    <= '0;
      idx_p2_q    <= '0;
      out_bits_q  <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      act_q       <= act_d;
      w_ren_q     <= w_ren_d;
      w_addr_q    <= w_addr_d;
      issue_cnt_q <= issue_cnt_d;
      got_cnt_q   <= got_cnt_d;
      vld_p0_q    <= vld_p0_d;
      vld_p1_q    <= vld_p1_d;
      vld_p2_q    <= vld_p2_d;
      idx_p0_q    <= idx_p0_d;
      idx_p1_q    <= idx_p1_d;
      idx_p2_q    <= idx_p2_d;
      out_bits_q  <= out_bits_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.w_ren     = w_ren_q;
  assign bus.w_addr    = w_addr_q;
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.out_bits  = out_bits_q;
  assign bus.busy      = (state_q != S_IDLE);
endmodule
